// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU/PC select codes,
// FSM state encodings and decoded instruction classes.
package cu_pkg;

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_ADD   = 1;
  localparam int unsigned OP_SUB   = 2;
  localparam int unsigned OP_AND   = 3;
  localparam int unsigned OP_OR    = 4;
  localparam int unsigned OP_ADDI  = 5;
  localparam int unsigned OP_SUBI  = 6;
  localparam int unsigned OP_ANDI  = 7;
  localparam int unsigned OP_ORI   = 8;
  localparam int unsigned OP_JUMP  = 9;
  localparam int unsigned OP_BEQ   = 10;
  localparam int unsigned OP_BNE   = 11;
  localparam int unsigned OP_LOAD  = 12;
  localparam int unsigned OP_STORE = 13;
  localparam int unsigned OP_HALT  = 14;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_JMP = 2'd1;
  localparam logic [1:0] PC_BR  = 2'd2;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } cu_state_e;

  typedef enum logic [3:0] {
    ClsNop,
    ClsAlu,
    ClsJump,
    ClsBeq,
    ClsBne,
    ClsLoad,
    ClsStore,
    ClsHalt,
    ClsIllegal
  } cu_class_e;

endpackage

// File: rtl/cu_op_decoder.sv
// Combinational opcode decoder: latched opcode to instruction class, ALU select,
// operand-1 select and illegal flag.
module cu_op_decoder
  import cu_pkg::*;
#(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned ALU_SEL_W = 2
) (
  input  logic [OP_W-1:0]      op,
  output cu_class_e            op_class,
  output logic [ALU_SEL_W-1:0] alu_op_sel,
  output logic                 operand_1_sel,
  output logic                 illegal
);

  logic [1:0]  alu_code;
  int unsigned op_val;

  always_comb begin
    op_class      = ClsIllegal;
    alu_code      = ALU_ADD;
    operand_1_sel = 1'b0;
    op_val        = 32'(op);
    case (op_val)
      OP_NOP: op_class = ClsNop;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        op_class = ClsAlu;
        alu_code = 2'(op_val - OP_ADD);
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        op_class      = ClsAlu;
        alu_code      = 2'(op_val - OP_ADDI);
        operand_1_sel = 1'b1;
      end
      OP_JUMP: op_class = ClsJump;
      OP_BEQ: begin
        op_class = ClsBeq;
        alu_code = ALU_SUB;
      end
      OP_BNE: begin
        op_class = ClsBne;
        alu_code = ALU_SUB;
      end
      // Loads and stores use the ALU for base + immediate address calculation.
      OP_LOAD: begin
        op_class      = ClsLoad;
        operand_1_sel = 1'b1;
      end
      OP_STORE: begin
        op_class      = ClsStore;
        operand_1_sel = 1'b1;
      end
      OP_HALT: op_class = ClsHalt;
      default: op_class = ClsIllegal;
    endcase
  end

  assign illegal    = (op_class == ClsIllegal);
  assign alu_op_sel = ALU_SEL_W'(alu_code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit: sequences fetch/decode/execute/mem/writeback with a
// ready-based memory handshake, branch, load/store, halt and illegal-opcode handling.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned ALU_SEL_W = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [OP_W-1:0]      in_op_code,
  input  logic                 in_alu_zero,
  input  logic                 in_mem_ready,
  output logic                 out_mem_req,
  output logic                 out_mem_wr_en,
  output logic                 out_ir_wr_en,
  output logic                 out_pc_wr_en,
  output logic [1:0]           out_pc_mux_sel,
  output logic                 out_reg_file_wr_en,
  output logic                 out_reg_wr_src_sel,
  output logic [ALU_SEL_W-1:0] out_alu_op_sel,
  output logic                 out_alu_operand_1_sel,
  output logic                 out_halted,
  output logic                 out_illegal,
  output logic [2:0]           out_state
);

  cu_state_e             state_q, state_d;
  logic [OP_W-1:0]       op_q;
  cu_class_e             op_class;
  logic [ALU_SEL_W-1:0]  dec_alu_op_sel;
  logic                  dec_operand_1_sel;
  logic                  dec_illegal;

  cu_op_decoder #(
    .OP_W      (OP_W),
    .ALU_SEL_W (ALU_SEL_W)
  ) u_op_decoder (
    .op            (op_q),
    .op_class      (op_class),
    .alu_op_sel    (dec_alu_op_sel),
    .operand_1_sel (dec_operand_1_sel),
    .illegal       (dec_illegal)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) begin
        op_q <= in_op_code;
      end
    end
  end

  always_comb begin
    state_d               = state_q;
    out_mem_req           = 1'b0;
    out_mem_wr_en         = 1'b0;
    out_ir_wr_en          = 1'b0;
    out_pc_wr_en          = 1'b0;
    out_pc_mux_sel        = PC_INC;
    out_reg_file_wr_en    = 1'b0;
    out_reg_wr_src_sel    = 1'b0;
    out_alu_op_sel        = '0;
    out_alu_operand_1_sel = 1'b0;
    out_halted            = 1'b0;
    out_illegal           = 1'b0;

    unique case (state_q)
      StFetch: begin
        out_mem_req = 1'b1;
        if (in_mem_ready) begin
          out_ir_wr_en = 1'b1;
          out_pc_wr_en = 1'b1;
          state_d      = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        out_alu_op_sel        = dec_alu_op_sel;
        out_alu_operand_1_sel = dec_operand_1_sel;
        state_d               = StFetch;
        case (op_class)
          ClsAlu: state_d = StWriteback;
          ClsJump: begin
            out_pc_wr_en   = 1'b1;
            out_pc_mux_sel = PC_JMP;
          end
          ClsBeq: begin
            out_pc_wr_en   = in_alu_zero;
            out_pc_mux_sel = PC_BR;
          end
          ClsBne: begin
            out_pc_wr_en   = !in_alu_zero;
            out_pc_mux_sel = PC_BR;
          end
          ClsLoad, ClsStore: state_d = StMem;
          ClsHalt: state_d = StHalt;
          default: out_illegal = dec_illegal;
        endcase
      end
      StMem: begin
        out_mem_req           = 1'b1;
        out_mem_wr_en         = (op_class == ClsStore);
        out_alu_op_sel        = dec_alu_op_sel;
        out_alu_operand_1_sel = dec_operand_1_sel;
        if (in_mem_ready) begin
          state_d = (op_class == ClsLoad) ? StWriteback : StFetch;
        end
      end
      StWriteback: begin
        out_reg_file_wr_en    = 1'b1;
        out_reg_wr_src_sel    = (op_class == ClsLoad);
        out_alu_op_sel        = dec_alu_op_sel;
        out_alu_operand_1_sel = dec_operand_1_sel;
        state_d               = StFetch;
      end
      StHalt: out_halted = 1'b1;
      default: state_d = StFetch;
    endcase

    // Outputs are gated so a request or write drops the instant reset rises.
    if (in_rst) begin
      out_mem_req           = 1'b0;
      out_mem_wr_en         = 1'b0;
      out_ir_wr_en          = 1'b0;
      out_pc_wr_en          = 1'b0;
      out_pc_mux_sel        = PC_INC;
      out_reg_file_wr_en    = 1'b0;
      out_reg_wr_src_sel    = 1'b0;
      out_alu_op_sel        = '0;
      out_alu_operand_1_sel = 1'b0;
      out_halted            = 1'b0;
      out_illegal           = 1'b0;
    end
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction expected output traces built from the instruction
// rules, driven with randomized ready/zero/opcode stimulus and compared every cycle.
module tb_multicycle_control_unit;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b1;
  logic [4:0] in_op_code = '0;
  logic       in_alu_zero = 1'b0;
  logic       in_mem_ready = 1'b0;
  logic       out_mem_req, out_mem_wr_en, out_ir_wr_en, out_pc_wr_en;
  logic [1:0] out_pc_mux_sel;
  logic       out_reg_file_wr_en, out_reg_wr_src_sel;
  logic [1:0] out_alu_op_sel;
  logic       out_alu_operand_1_sel, out_halted, out_illegal;
  logic [2:0] out_state;

  int errors = 0;
  int checks = 0;

  multicycle_control_unit #(
    .OP_W      (5),
    .ALU_SEL_W (2)
  ) dut (
    .in_clk                (in_clk),
    .in_rst                (in_rst),
    .in_op_code            (in_op_code),
    .in_alu_zero           (in_alu_zero),
    .in_mem_ready          (in_mem_ready),
    .out_mem_req           (out_mem_req),
    .out_mem_wr_en         (out_mem_wr_en),
    .out_ir_wr_en          (out_ir_wr_en),
    .out_pc_wr_en          (out_pc_wr_en),
    .out_pc_mux_sel        (out_pc_mux_sel),
    .out_reg_file_wr_en    (out_reg_file_wr_en),
    .out_reg_wr_src_sel    (out_reg_wr_src_sel),
    .out_alu_op_sel        (out_alu_op_sel),
    .out_alu_operand_1_sel (out_alu_operand_1_sel),
    .out_halted            (out_halted),
    .out_illegal           (out_illegal),
    .out_state             (out_state)
  );

  always #5 in_clk = ~in_clk;

  // Output vector layout: req wr ir pcw sel[1:0] rf src alu[1:0] opnd halted illegal state[2:0]
  logic [15:0] obs;
  assign obs = {out_mem_req, out_mem_wr_en, out_ir_wr_en, out_pc_wr_en, out_pc_mux_sel,
                out_reg_file_wr_en, out_reg_wr_src_sel, out_alu_op_sel,
                out_alu_operand_1_sel, out_halted, out_illegal, out_state};

  typedef struct packed {
    logic [15:0] exp;
    logic        ready;
    logic        zero;
    logic [4:0]  op;
  } cyc_t;

  cyc_t trace[$];

  function automatic logic [15:0] mk(input logic req, input logic wr, input logic ir,
                                     input logic pcw, input int sel, input logic rf,
                                     input logic src, input int alu, input logic opnd,
                                     input logic halted, input logic ill, input int st);
    return {req, wr, ir, pcw, 2'(sel), rf, src, 2'(alu), opnd, halted, ill, 3'(st)};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [4:0] rop();
    return 5'($urandom);
  endfunction

  function automatic void push(input logic [15:0] e, input logic r, input logic z,
                               input logic [4:0] op);
    cyc_t c;
    c.exp   = e;
    c.ready = r;
    c.zero  = z;
    c.op    = op;
    trace.push_back(c);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction. The opcode is presented only in
  // the decode cycle; every other cycle carries random opcode, zero and don't-care ready.
  function automatic void build(input int op, input int fw, input int mw, input logic z);
    bit is_alu, is_imm, is_ld, is_st, is_br, is_ill;
    int alu;
    logic opnd, pcw;
    int sel;
    is_alu = (op >= 1 && op <= 4);
    is_imm = (op >= 5 && op <= 8);
    is_ld  = (op == 12);
    is_st  = (op == 13);
    is_br  = (op == 10 || op == 11);
    is_ill = (op >= 15);
    alu    = is_alu ? op - 1 : is_imm ? op - 5 : is_br ? 1 : 0;
    opnd   = is_imm || is_ld || is_st;
    pcw    = (op == 9) || (op == 10 && z) || (op == 11 && !z);
    sel    = (op == 9) ? 1 : is_br ? 2 : 0;
    for (int i = 0; i < fw; i++) push(mk(1,0,0,0,0,0,0,0,0,0,0,0), 1'b0, rb(), rop());
    push(mk(1,0,1,1,0,0,0,0,0,0,0,0), 1'b1, rb(), rop());
    push(mk(0,0,0,0,0,0,0,0,0,0,0,1), rb(), rb(), 5'(op));
    push(mk(0,0,0,pcw,sel,0,0,alu,opnd,0,is_ill,2), rb(), z, rop());
    if (is_ld || is_st) begin
      for (int i = 0; i < mw; i++) push(mk(1,is_st,0,0,0,0,0,0,1,0,0,3), 1'b0, rb(), rop());
      push(mk(1,is_st,0,0,0,0,0,0,1,0,0,3), 1'b1, rb(), rop());
    end
    if (is_alu || is_imm || is_ld) push(mk(0,0,0,0,0,1,is_ld,alu,opnd,0,0,4), rb(), rb(), rop());
  endfunction

  task automatic step(input logic r, input logic z, input logic [4:0] op,
                      output logic [15:0] o);
    @(negedge in_clk);
    in_mem_ready = r;
    in_alu_zero  = z;
    in_op_code   = op;
    #1;
    o = obs;
  endtask

  task automatic test_reset();
    logic [15:0] o;
    in_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rb(), rop(), o);
      checks++;
      if (o !== 16'h0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, o, 16'h0);
      end
    end
    @(negedge in_clk);
    in_mem_ready = 1'b0;
    in_rst = 1'b0;
  endtask

  task automatic test_alu_op();
    logic [15:0] o;
    trace.delete();
    build(1, 0, 0, 1'b0);
    build(7, 1, 0, 1'b1);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL alu_op cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [15:0] o;
    trace.delete();
    build(12, 0, 3, 1'b0);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL load_wait cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] o;
    trace.delete();
    build(10, 0, 0, 1'b1);
    build(10, 0, 0, 1'b0);
    build(11, 0, 0, 1'b0);
    build(11, 2, 0, 1'b1);
    build(9, 0, 0, 1'b0);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL branch cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  task automatic test_store();
    logic [15:0] o;
    trace.delete();
    build(13, 0, 0, 1'b0);
    build(13, 1, 2, 1'b1);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL store cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] o;
    int op;
    trace.delete();
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 31);
      if (op == 14) op = 0;
      build(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [15:0] o;
    trace.delete();
    build(13, 0, 2, 1'b0);
    // Entries 0..3 are fetch, decode, execute and the first MEM cycle.
    for (int i = 0; i < 4; i++) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL rst_mem_pre cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
    in_mem_ready = 1'b0;
    in_rst = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0) begin
      errors++;
      $display("FAIL rst_mem_drop: got %h expected %h", obs, 16'h0);
    end
    @(negedge in_clk);
    in_rst = 1'b0;
    #1;
    checks++;
    if (obs !== mk(1,0,0,0,0,0,0,0,0,0,0,0)) begin
      errors++;
      $display("FAIL rst_mem_resume: got %h expected %h", obs, mk(1,0,0,0,0,0,0,0,0,0,0,0));
    end
    trace.delete();
    build(2, 0, 0, 1'b0);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL rst_mem_post cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  task automatic test_illegal_halt();
    logic [15:0] o;
    trace.delete();
    build(20, 0, 0, 1'b0);
    build(31, 1, 0, 1'b1);
    build(14, 0, 0, 1'b0);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL illegal_halt cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(rb(), rb(), rop(), o);
      checks++;
      if (o !== mk(0,0,0,0,0,0,0,0,0,1,0,5)) begin
        errors++;
        $display("FAIL halt_sticky cycle %0d: got %h expected %h", i, o,
                 mk(0,0,0,0,0,0,0,0,0,1,0,5));
      end
    end
    // Only reset leaves HALT.
    test_reset();
    trace.delete();
    build(4, 0, 0, 1'b0);
    foreach (trace[i]) begin
      step(trace[i].ready, trace[i].zero, trace[i].op, o);
      checks++;
      if (o !== trace[i].exp) begin
        errors++;
        $display("FAIL after_halt cycle %0d: got %h expected %h", i, o, trace[i].exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_branch();
    test_store();
    test_reset_mid_mem();
    test_back_to_back();
    test_illegal_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle combinational opcode decoder: a multi-cycle FSM control unit for the microprocessor datapath.
- Sequences fetch, decode, execute, memory and writeback phases.
- Adds branch, load/store, halt and illegal-opcode handling on top of the existing ALU/immediate/jump set.
- Adds a ready-based memory handshake.
- Parametrised in opcode width and ALU select width.
- Sits between the instruction register and the datapath muxes, register file, ALU and memory.

Parameters:
- OP_W, 5, opcode width; opcodes >= 15 are illegal.
- ALU_SEL_W, 2, ALU op select width; codes 0 add, 1 sub, 2 and, 3 or; upper bits zero.

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  reset, asynchronous, active-high
- in_op_code  input  OP_W  opcode from instruction register; valid from DECODE onward
- in_alu_zero  input  1  ALU result-zero flag, combinational from datapath
- in_mem_ready  input  1  memory completes current request this cycle
- out_mem_req  output  1  memory request (fetch or data)
- out_mem_wr_en  output  1  data write (store), only with out_mem_req
- out_ir_wr_en  output  1  load instruction register
- out_pc_wr_en  output  1  update PC
- out_pc_mux_sel  output  2  0 = PC+1, 1 = jump target, 2 = branch target
- out_reg_file_wr_en  output  1  register file write
- out_reg_wr_src_sel  output  1  0 = ALU result, 1 = memory data
- out_alu_op_sel  output  ALU_SEL_W  ALU operation
- out_alu_operand_1_sel  output  1  0 = register, 1 = immediate
- out_halted  output  1  core halted (sticky)
- out_illegal  output  1  one-cycle pulse on illegal opcode
- out_state  output  3  current state encoding, for debug

Behaviour:
- Opcodes:
  - 0 nop
  - 1-4 add/sub/and/or (reg)
  - 5-8 addi/subi/andi/ori (operand_1_sel = 1)
  - 9 jump
  - 10 beq
  - 11 bne
  - 12 load
  - 13 store
  - 14 halt
  - others illegal
- States: FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WRITEBACK = 4, HALT = 5.
- Reset (asynchronous): state = FETCH, op_q = 0.
  - All outputs 0 while in_rst is high, except out_state = 0.
- Default for every output is 0 unless listed for the state below.
- FETCH:
  - out_mem_req = 1.
  - When in_mem_ready = 1: out_ir_wr_en = 1, out_pc_wr_en = 1, pc_mux_sel = 0, go to DECODE.
  - Otherwise stay in FETCH with request held.
- DECODE: register in_op_code into op_q; always go to EXECUTE.
- EXECUTE: alu_op_sel and operand_1_sel are driven from op_q. Actions by class:
  - ALU/imm: go to WRITEBACK.
  - jump: pc_wr_en = 1, pc_mux_sel = 1, go to FETCH.
  - beq/bne: alu_op_sel = sub, operand_1_sel = 0. pc_wr_en = in_alu_zero for beq, !in_alu_zero for bne, with pc_mux_sel = 2. Go to FETCH.
  - load/store: alu_op_sel = add, operand_1_sel = 1 (address calculation). Go to MEM.
  - nop: go to FETCH.
  - halt: go to HALT.
  - illegal: out_illegal = 1 for this cycle; treated as nop; go to FETCH.
- MEM:
  - out_mem_req = 1; out_mem_wr_en = 1 for store. alu_op_sel = add and operand_1_sel = 1 are held.
  - Stay in MEM until in_mem_ready = 1.
  - Then load goes to WRITEBACK; store goes to FETCH.
- WRITEBACK:
  - reg_file_wr_en = 1.
  - wr_src_sel = 1 for load, else 0.
  - alu_op_sel and operand_1_sel are held from op_q.
  - Go to FETCH.
- HALT: out_halted = 1; no requests or writes; leave only on reset.
- Latency with in_mem_ready tied high:
  - ALU/imm: 4 cycles.
  - jump/branch/nop: 3 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - Each ready-low cycle adds one cycle.
- in_mem_ready is ignored outside FETCH and MEM.
- in_alu_zero is ignored outside EXECUTE of beq/bne.
- Reset mid-MEM or mid-FETCH: request drops immediately (asynchronous); no write or PC update occurs.
- op_q is zero-extended/compared at OP_W bits; illegal detection covers all values >= 15.

Decomposition:
- Shared package cu_pkg holds:
  - opcode constants OP_NOP … OP_HALT;
  - ALU select codes ALU_ADD/SUB/AND/OR;
  - PC mux codes PC_INC/PC_JMP/PC_BR;
  - state encodings.
- One sub-module, cu_op_decoder (combinational): op_q to instruction class, alu_op_sel, operand_1_sel, illegal flag.
- The FSM and output logic stay in multicycle_control_unit.

Test Plan:
- Reset, then opcode 1 with ready = 1 → FETCH, DECODE, EXECUTE, WRITEBACK. reg_file_wr_en = 1 in cycle 4 with alu_op_sel = 0 and wr_src_sel = 0; back to FETCH in cycle 5.
- Opcode 12 (load), ready low for 3 MEM cycles → mem_req held 4 MEM cycles with wr_en = 0. Then WRITEBACK with wr_src_sel = 1; total 8 cycles.
- Opcode 10 with in_alu_zero = 1 → EXECUTE pc_wr_en = 1, pc_mux_sel = 2. Opcode 10 with in_alu_zero = 0 → pc_wr_en = 0. Opcode 11 with in_alu_zero = 0 → branch taken.
- Opcode 13 (store), ready = 1 → MEM has mem_req = 1 and mem_wr_en = 1; no reg_file_wr_en ever; back to FETCH after 4 cycles.
- Opcode 20 (illegal) → out_illegal pulses exactly 1 cycle in EXECUTE; next state FETCH. Then opcode 14 → out_halted = 1 sticky, mem_req stays 0 for 10+ cycles.
- Assert in_rst during MEM of a store → mem_req and mem_wr_en drop in the same cycle; state = 0; after release, FETCH resumes with mem_req = 1.
